// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and widths for the register-file write-back arbiter.
// Widths follow the CPU configuration macros when present; otherwise RV32 defaults are used.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef REG_ADDRW
`define REG_ADDRW 5
`endif

package wb_pkg;

  localparam int CPU_WIDTH  = `CPU_WIDTH;
  localparam int REG_ADDRW  = `REG_ADDRW;
  localparam int WB_MAX_REQ = 4;

  typedef struct packed {
    logic [`REG_ADDRW-1:0] addr;
    logic [`CPU_WIDTH-1:0] data;
  } wb_req_t;

  // Width of an encoded requester index; never zero so single-bit vectors stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of requester handshakes, regfile write port and decode forwarding taps.
// master = requesters/decode side, slave = the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 2
);
  import wb_pkg::*;

  logic [NREQ-1:0]                req_valid;
  logic [NREQ-1:0]                req_ready;
  logic [NREQ-1:0][REG_ADDRW-1:0] req_addr;
  logic [NREQ-1:0][CPU_WIDTH-1:0] req_data;

  logic                           wen;
  logic [REG_ADDRW-1:0]           waddr;
  logic [CPU_WIDTH-1:0]           wdata;

  logic [REG_ADDRW-1:0]           raddr1;
  logic [REG_ADDRW-1:0]           raddr2;
  logic                           fwd1_hit;
  logic                           fwd2_hit;
  logic [CPU_WIDTH-1:0]           fwd_data;

  modport master (
    output req_valid, req_addr, req_data, raddr1, raddr2,
    input  req_ready, wen, waddr, wdata, fwd1_hit, fwd2_hit, fwd_data
  );

  modport slave (
    input  req_valid, req_addr, req_data, raddr1, raddr2,
    output req_ready, wen, waddr, wdata, fwd1_hit, fwd2_hit, fwd_data
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin grant: search starts one past the last winner and wraps.
// Produces a one-hot grant, the encoded winner and an any-grant flag.
module rr_arbiter
  import wb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // cand[i] is the requester examined i-th in this cycle's search order.
  logic [IW-1:0] cand [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    assign cand[gi] = IW'((int'(last) + 1 + gi) % N);
  end

  always_comb begin
    grant = '0;
    idx   = last;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[cand[i]]) begin
        any            = 1'b1;
        idx            = cand[i];
        grant[cand[i]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbitration of write-back requesters onto the single regfile write port,
// through one staging register that also feeds the decode forwarding path.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IW   = idx_width(NREQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  regfile_wb_arbiter_if.slave       bus
);

  if (NREQ < 2 || NREQ > WB_MAX_REQ) begin : g_bad_nreq
    $error("regfile_wb_arbiter: NREQ must be in 2..WB_MAX_REQ");
  end

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   win_idx;
  logic            win_any;
  wb_req_t         win_req;

  logic [IW-1:0]   rr_last_reg;
  logic [IW-1:0]   rr_last_next;
  logic            stg_wen_reg;
  logic            stg_wen_next;
  wb_req_t         stg_reg;
  wb_req_t         stg_next;

  rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .req   (bus.req_valid),
    .last  (rr_last_reg),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  always_comb begin
    win_req.addr = bus.req_addr[win_idx];
    win_req.data = bus.req_data[win_idx];
  end

  // x0 writes are accepted and advance the pointer but never enable the regfile.
  always_comb begin
    rr_last_next = rr_last_reg;
    stg_wen_next = 1'b0;
    stg_next     = stg_reg;
    if (win_any) begin
      rr_last_next = win_idx;
      stg_wen_next = (win_req.addr != '0);
      stg_next     = win_req;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_last_reg <= IW'(NREQ - 1);
      stg_wen_reg <= 1'b0;
      stg_reg     <= '0;
    end else begin
      rr_last_reg <= rr_last_next;
      stg_wen_reg <= stg_wen_next;
      stg_reg     <= stg_next;
    end
  end

  assign bus.req_ready = grant;

  // Gating with reset drops a write still staged at the reset edge before the regfile sees it.
  assign bus.wen      = stg_wen_reg & ~i_rst;
  assign bus.waddr    = stg_reg.addr;
  assign bus.wdata    = stg_reg.data;

  assign bus.fwd1_hit = stg_wen_reg && (stg_reg.addr == bus.raddr1);
  assign bus.fwd2_hit = stg_wen_reg && (stg_reg.addr == bus.raddr2);
  assign bus.fwd_data = stg_reg.data;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between `NREQ` write-back requesters (EXU result, LSU load data, CSR read-back, ...). Uses fair round-robin arbitration with a valid/ready handshake. The granted write goes into one staging register that drives the regfile write port on the next cycle. The block also gives the decode stage a forwarding path for a write that is staged but not yet committed.

## Interface
Parameters:
- `NREQ`, default 2: number of write-back requesters, 2..4.

Ports:
- `i_clk`  in  1  clock; all state updates on its rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_req_valid`  in  NREQ  requester k has a write pending.
- `o_req_ready`  out  NREQ  requester k's write is accepted this cycle.
- `i_req_addr`  in  NREQ × `REG_ADDRW`  destination register per requester.
- `i_req_data`  in  NREQ × `CPU_WIDTH`  write data per requester.
- `o_wen`  out  1  regfile write enable.
- `o_waddr`  out  `REG_ADDRW`  regfile write address.
- `o_wdata`  out  `CPU_WIDTH`  regfile write data.
- `i_raddr1`, `i_raddr2`  in  `REG_ADDRW`  decode-stage read addresses.
- `o_fwd1_hit`, `o_fwd2_hit`  out  1  staged write matches read address 1 / 2.
- `o_fwd_data`  out  `CPU_WIDTH`  staged write data, for forwarding.

## Operation
- **State**
  - Staging register `{stg_wen, stg_addr, stg_data}`.
  - Round-robin pointer `rr_last`, width clog2(NREQ): index of the last granted requester.
- **Arbitration** (combinational)
  - Search order starts at `rr_last+1`, modulo NREQ, and wraps.
  - The first requester with `i_req_valid`=1 is granted.
  - `o_req_ready` is one-hot on the winner and all-zero when nothing is valid.
  - Ready never depends on anything other than the valids and `rr_last`.
- **Handshake**
  - A write transfers when `valid && ready`.
  - A requester holds `valid`, `addr` and `data` stable until it sees ready.
  - Deasserting valid before ready is a protocol violation and is not checked.
- **Accept** (on the clock edge, when any grant occurs)
  - `stg_addr` ← winner's addr; `stg_data` ← winner's data.
  - `stg_wen` ← (winner's addr != 0).
  - `rr_last` ← winner index.
- **Idle cycle** (no grant)
  - `stg_wen` ← 0; `stg_addr` and `stg_data` hold; `rr_last` holds.
- **x0 writes**
  - Are arbitrated and accepted normally and advance `rr_last`.
  - Are never presented to the regfile: `o_wen` stays 0.
- **Output drive**
  - `o_wen`/`o_waddr`/`o_wdata` = staging register.
  - The regfile is always writable, so the stage drains every cycle and there is no back-pressure path.
- **Forwarding**
  - `o_fwdN_hit` = `stg_wen` && (`stg_addr` == `i_raddrN`). Combinational from the stage; x0 can never hit because `stg_wen` is 0 for it.
  - `o_fwd_data` = `stg_data`.
- **Ordering**
  - Two requesters targeting the same register in the same cycle are serialized in arbitration order.
  - Program-order correctness for that case belongs to the issuing pipeline, not to this block.

## Timing
- **Reset values**
  - `stg_wen`=0, `stg_addr`=0, `stg_data`=0.
  - `rr_last`=NREQ-1, so requester 0 wins first.
  - Hence `o_wen`=0, `o_waddr`=0, `o_wdata`=0, both fwd hits 0.
- **Latency**
  - Handshake in cycle T → `o_wen` high in cycle T+1 → register value visible in the regfile from T+2.
  - Forwarding covers the T+1 read window.
- **Throughput and fairness**
  - One write accepted per cycle.
  - A continuously valid requester waits at most NREQ-1 cycles.
- **Reset mid-operation**
  - A staged write present at the reset edge is discarded: it never reaches the regfile.
  - A requester holding valid across reset is re-arbitrated from the reset pointer.
- **Simultaneous events**
  - A new accept and the drain of the previous stage happen on the same edge.
  - Back-to-back writes to the same register appear on consecutive cycles in grant order.

## Structure
- Package `wb_pkg`:
  - `typedef struct packed {logic [`REG_ADDRW-1:0] addr; logic [`CPU_WIDTH-1:0] data;} wb_req_t`.
  - Localparam `WB_MAX_REQ` = 4.
  - Widths come from the existing `config.sv` macros.
- Sub-module `rr_arbiter #(N)`:
  - Purely combinational grant from (req vector, last index).
  - Outputs a one-hot grant plus encoded winner index.
  - `regfile_wb_arbiter` instantiates it and owns the pointer and staging registers.

## Test plan
- **Reset output:** assert `i_rst` 2 cycles with requesters idle → all outputs 0; first grant after release goes to requester 0.
- **Simultaneous requests:** NREQ=2, both valid continuously, req0 writes x5=0x11, req1 writes x6=0x22 → grants alternate 0,1,0,1. `o_wen`/`o_waddr` show 5,6,5,6 from cycle T+1.
- **x0 squash:** req0 writes x0=0xFFFF → `o_req_ready[0]`=1, next cycle `o_wen`=0, x0 reads 0, `rr_last` advanced to 0.
- **Forwarding:** accept x7=0xDEAD in cycle T. In T+1 with `i_raddr1`=7, `i_raddr2`=8 → `o_fwd1_hit`=1, `o_fwd2_hit`=0, `o_fwd_data`=0xDEAD. In T+2 both hits are 0.
- **Reset during staged write:** accept x9=0x55 in cycle T, assert `i_rst` at the T+1 edge → `o_wen` never asserts for x9 and the regfile x9 is unchanged.
- **Fairness:** NREQ=4, requesters 1 and 3 valid continuously → grant sequence 1,3,1,3. No requester waits more than 3 cycles.
